// File: rtl/m_cg_bank_pkg.sv
// m_cg_bank_pkg: shared types and default parameters for the clock-gate bank.
// Optional statistics counters are built when M_CG_BANK_STATS_EN is defined.
package m_cg_bank_pkg;

    // Per-channel gate state
    typedef enum logic [1:0] {
        CH_ON   = 2'd0,
        CH_OFF  = 2'd1,
        CH_WAKE = 2'd2
    } ch_state_e;

    localparam int DEF_NCH      = 4;
    localparam int DEF_IDLE_W   = 8;
    localparam int DEF_WAKE_CYC = 2;
`ifdef M_CG_BANK_STATS_EN
    localparam int DEF_STAT_W   = 16;
`endif

endpackage

// File: rtl/m_cg.sv
// m_cg: latch-based integrated clock gate. The enable is captured while the
// clock is low, so it cannot change during the high phase and ECK is glitch-free.
module m_cg (
    input  logic ck_i,
    input  logic e_i,
    input  logic se_i,
    output logic eck_o
);

    logic en_l;

    // Transparent-low latch holding the combined functional/scan enable
    always_latch begin
        if (!ck_i) en_l = e_i | se_i;
    end

    assign eck_o = ck_i & en_l;

endmodule

// File: rtl/m_cg_bank_ch.sv
// m_cg_bank_ch: one auto-gated clock channel (idle counter, ON/OFF/WAKE FSM,
// wake counter, m_cg cell). OFF-cycle statistics exist when
// M_CG_BANK_STATS_EN is defined.
//
// Wake handshake: activity (busy_i | force_on_i) sampled in OFF is the
// request; rdy_o is the acknowledge. rdy_o stays low until exactly WAKE_CYC
// gated pulses have been delivered on eck_o, then rises and stays high until
// the channel gates again. Requests seen during WAKE are not queued.
module m_cg_bank_ch
    import m_cg_bank_pkg::*;
#(
    parameter int IDLE_W   = DEF_IDLE_W,
    parameter int WAKE_CYC = DEF_WAKE_CYC
`ifdef M_CG_BANK_STATS_EN
    ,
    parameter int STAT_W   = DEF_STAT_W
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              se_i,
    input  logic [IDLE_W-1:0] idle_lim_i,
    input  logic              force_on_i,
    input  logic              busy_i,
    output logic              eck_o,
    output logic              rdy_o,
    output ch_state_e         state_o
`ifdef M_CG_BANK_STATS_EN
    ,
    input  logic              stat_clr_i,
    output logic [STAT_W-1:0] stat_cnt_o
`endif
);

    localparam int WCNT_W = (WAKE_CYC < 2) ? 1 : $clog2(WAKE_CYC + 1);
    localparam logic [WCNT_W-1:0] WAKE_LOAD = WCNT_W'(WAKE_CYC);

    ch_state_e         state_q;
    logic              en_q;
    logic              rdy_q;
    logic [IDLE_W-1:0] cnt_q;
    logic [IDLE_W-1:0] cnt_d;
    logic [WCNT_W-1:0] wcnt_q;
    logic              act;

    assign act   = busy_i | force_on_i;
    // Saturating increment of the idle run length
    assign cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + IDLE_W'(1);

    // Channel FSM; en_q is a flop output so the gate enable never sees busy_i combinationally
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CH_ON;
            en_q    <= 1'b1;
            rdy_q   <= 1'b1;
            cnt_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            case (state_q)
                CH_ON: begin
                    if (act || (idle_lim_i == '0)) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_d >= idle_lim_i) begin
                            state_q <= CH_OFF;
                            en_q    <= 1'b0;
                            rdy_q   <= 1'b0;
                        end
                    end
                end
                CH_OFF: begin
                    if (act) begin
                        en_q <= 1'b1;
                        if (WAKE_CYC == 0) begin
                            state_q <= CH_ON;
                            rdy_q   <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= CH_WAKE;
                            wcnt_q  <= WAKE_LOAD;
                        end
                    end
                end
                CH_WAKE: begin
                    if (wcnt_q <= WCNT_W'(1)) begin
                        state_q <= CH_ON;
                        rdy_q   <= 1'b1;
                        cnt_q   <= '0;
                        wcnt_q  <= '0;
                    end else begin
                        wcnt_q <= wcnt_q - WCNT_W'(1);
                    end
                end
                default: begin
                    state_q <= CH_ON;
                    en_q    <= 1'b1;
                    rdy_q   <= 1'b1;
                    cnt_q   <= '0;
                    wcnt_q  <= '0;
                end
            endcase
        end
    end

    assign rdy_o   = rdy_q;
    assign state_o = state_q;

    m_cg u_cg (
        .ck_i  (clk_i),
        .e_i   (en_q),
        .se_i  (se_i),
        .eck_o (eck_o)
    );

`ifdef M_CG_BANK_STATS_EN
    logic [STAT_W-1:0] stat_q;

    // Saturating count of edges spent in OFF; clear wins over increment
    always_ff @(posedge clk_i) begin
        if (rst_i || stat_clr_i) begin
            stat_q <= '0;
        end else if ((state_q == CH_OFF) && (stat_q != '1)) begin
            stat_q <= stat_q + STAT_W'(1);
        end
    end

    assign stat_cnt_o = stat_q;
`endif

endmodule

// File: rtl/m_cg_bank.sv
// m_cg_bank: bank of NCH independent automatic clock gates sharing the idle
// threshold and scan enable. Define M_CG_BANK_STATS_EN to add STAT_CLR and the
// per-channel OFF-cycle counters on STAT_CNT.
module m_cg_bank
    import m_cg_bank_pkg::*;
#(
    parameter int NCH      = DEF_NCH,
    parameter int IDLE_W   = DEF_IDLE_W,
    parameter int WAKE_CYC = DEF_WAKE_CYC
`ifdef M_CG_BANK_STATS_EN
    ,
    parameter int STAT_W   = DEF_STAT_W
`endif
) (
    input  logic                  CK,
    input  logic                  RST,
    input  logic                  SE,
    input  logic [IDLE_W-1:0]     IDLE_LIM,
    input  logic [NCH-1:0]        FORCE_ON,
    input  logic [NCH-1:0]        BUSY,
    output logic [NCH-1:0]        ECK,
    output logic [NCH-1:0]        RDY,
    output logic [NCH-1:0]        GATED
`ifdef M_CG_BANK_STATS_EN
    ,
    input  logic                  STAT_CLR,
    output logic [NCH*STAT_W-1:0] STAT_CNT
`endif
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        ch_state_e ch_state;

        m_cg_bank_ch #(
            .IDLE_W   (IDLE_W),
            .WAKE_CYC (WAKE_CYC)
`ifdef M_CG_BANK_STATS_EN
            ,
            .STAT_W   (STAT_W)
`endif
        ) u_ch (
            .clk_i      (CK),
            .rst_i      (RST),
            .se_i       (SE),
            .idle_lim_i (IDLE_LIM),
            .force_on_i (FORCE_ON[i]),
            .busy_i     (BUSY[i]),
            .eck_o      (ECK[i]),
            .rdy_o      (RDY[i]),
            .state_o    (ch_state)
`ifdef M_CG_BANK_STATS_EN
            ,
            .stat_clr_i (STAT_CLR),
            .stat_cnt_o (STAT_CNT[i*STAT_W +: STAT_W])
`endif
        );

        // GATED is a decode of the registered channel state
        assign GATED[i] = (ch_state == CH_OFF);
    end

endmodule

// File: tb/tb_m_cg_bank.sv
// tb_m_cg_bank: directed and randomized checks of m_cg_bank against a
// cycle-level reference model of the gating rules.
module tb_m_cg_bank;

    localparam int NCH      = 4;
    localparam int IDLE_W   = 8;
    localparam int WAKE_CYC = 2;
`ifdef M_CG_BANK_STATS_EN
    localparam int STAT_W   = 16;
    localparam int STAT_MAX = (1 << STAT_W) - 1;
`endif

    logic              CK = 1'b0;
    logic              RST;
    logic              SE;
    logic [IDLE_W-1:0] IDLE_LIM;
    logic [NCH-1:0]    FORCE_ON;
    logic [NCH-1:0]    BUSY;
    logic [NCH-1:0]    ECK;
    logic [NCH-1:0]    RDY;
    logic [NCH-1:0]    GATED;
`ifdef M_CG_BANK_STATS_EN
    logic                  STAT_CLR;
    logic [NCH*STAT_W-1:0] STAT_CNT;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int eck0_pulses = 0;
    int base;

    // Reference model: idle run length, OFF flag, remaining wake pulses
    int m_run  [NCH];
    bit m_off  [NCH];
    int m_wake [NCH];
    int m_stat [NCH];

    // ---------------- clock ----------------
    always #5 CK = ~CK;

    always @(posedge ECK[0]) eck0_pulses++;

    m_cg_bank dut (
        .CK       (CK),
        .RST      (RST),
        .SE       (SE),
        .IDLE_LIM (IDLE_LIM),
        .FORCE_ON (FORCE_ON),
        .BUSY     (BUSY),
        .ECK      (ECK),
        .RDY      (RDY),
        .GATED    (GATED)
`ifdef M_CG_BANK_STATS_EN
        ,
        .STAT_CLR (STAT_CLR),
        .STAT_CNT (STAT_CNT)
`endif
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one clock edge to the model using the inputs sampled at that edge
    task automatic model_step();
        for (int c = 0; c < NCH; c++) begin
            bit act;
            act = BUSY[c] | FORCE_ON[c];
`ifdef M_CG_BANK_STATS_EN
            if (RST || STAT_CLR) m_stat[c] = 0;
            else if (m_off[c] && m_stat[c] < STAT_MAX) m_stat[c]++;
`endif
            if (RST) begin
                m_off[c] = 0; m_wake[c] = 0; m_run[c] = 0;
            end else if (m_wake[c] > 0) begin
                m_wake[c]--;
                if (m_wake[c] == 0) m_run[c] = 0;
            end else if (m_off[c]) begin
                if (act) begin
                    m_off[c]  = 0;
                    m_wake[c] = WAKE_CYC;
                    m_run[c]  = 0;
                end
            end else begin
                if (act || IDLE_LIM == 0) m_run[c] = 0;
                else m_run[c]++;
                if (IDLE_LIM != 0 && m_run[c] >= int'(IDLE_LIM)) m_off[c] = 1;
            end
        end
    endtask

    // One clock cycle: edge, model update, compare all outputs, return at negedge
    task automatic cycle();
        bit en_before [NCH];
        @(posedge CK);
        for (int c = 0; c < NCH; c++) en_before[c] = !m_off[c];
        model_step();
        #1;
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("rdy%0d", c), 32'(RDY[c]), 32'(!m_off[c] && m_wake[c] == 0));
            check($sformatf("gated%0d", c), 32'(GATED[c]), 32'(m_off[c]));
            check($sformatf("eck%0d", c), 32'(ECK[c]), 32'(SE | en_before[c]));
`ifdef M_CG_BANK_STATS_EN
            check($sformatf("stat%0d", c), 32'(STAT_CNT[c*STAT_W +: STAT_W]), 32'(m_stat[c]));
`endif
        end
        @(negedge CK);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RST = 1'b1; SE = 1'b0; IDLE_LIM = '0; FORCE_ON = '0; BUSY = '1;
`ifdef M_CG_BANK_STATS_EN
        STAT_CLR = 1'b0;
`endif
        for (int c = 0; c < NCH; c++) begin
            m_run[c] = 0; m_off[c] = 0; m_wake[c] = 0; m_stat[c] = 0;
        end
        // First reset edge brings the flops out of X before checking starts
        @(posedge CK);
        @(negedge CK);
        cycles(2);
        check("reset_rdy", 32'(RDY), 32'hF);
        check("reset_gated", 32'(GATED), 32'h0);

        // Idle gating on channel 0 only
        RST = 1'b0; IDLE_LIM = 8'd3; BUSY = 4'b1110;
        cycles(2);
        check("idle_not_yet", 32'(GATED[0]), 32'h0);
        cycle();
        check("idle_gated", 32'(GATED), 32'h1);
        base = eck0_pulses;
        cycles(2);
        check("idle_no_pulses", 32'(eck0_pulses - base), 32'h0);

        // Wake handshake on channel 0 with a one-cycle BUSY pulse
        BUSY[0] = 1'b1;
        cycle();
        check("wake_gated_fall", 32'(GATED[0]), 32'h0);
        check("wake_rdy_k", 32'(RDY[0]), 32'h0);
        base = eck0_pulses;
        BUSY[0] = 1'b0;
        cycle();
        check("wake_rdy_k1", 32'(RDY[0]), 32'h0);
        cycle();
        check("wake_rdy_k2", 32'(RDY[0]), 32'h1);
        check("wake_pulses", 32'(eck0_pulses - base), 32'(WAKE_CYC));

        // Interrupted idle never reaches the threshold
        BUSY = '1; IDLE_LIM = 8'd4;
        cycles(3);
        for (int r = 0; r < 4; r++) begin
            BUSY[0] = 1'b0;
            cycles(3);
            BUSY[0] = 1'b1;
            cycle();
            check("interrupted_idle", 32'(GATED[0]), 32'h0);
        end

        // Threshold 0 disables gating
        IDLE_LIM = 8'd0; BUSY = '0;
        cycles(20);
        check("lim0_never_gates", 32'(GATED), 32'h0);

        // FORCE_ON wakes an OFF channel like BUSY
        IDLE_LIM = 8'd2;
        cycles(2);
        check("all_off", 32'(GATED), 32'hF);
        FORCE_ON = 4'b0010;
        cycle();
        FORCE_ON = '0;
        check("force_wake_gated", 32'(GATED[1]), 32'h0);
        check("force_wake_rdy", 32'(RDY[1]), 32'h0);
        cycles(2);
        check("force_rdy", 32'(RDY[1]), 32'h1);

        // Scan enable opens the gates without changing state
        cycles(3);
        SE = 1'b1;
        base = eck0_pulses;
        cycles(4);
        check("se_gated_held", 32'(GATED), 32'hF);
        check("se_pulses", 32'(eck0_pulses - base), 32'h4);
        SE = 1'b0;

        // Reset during WAKE
        BUSY = '1;
        cycle();
        BUSY = '0; RST = 1'b1;
        cycle();
        check("rst_wake_rdy", 32'(RDY), 32'hF);
        check("rst_wake_gated", 32'(GATED), 32'h0);
        RST = 1'b0;

`ifdef M_CG_BANK_STATS_EN
        // Ten edges in OFF, clear coinciding with an OFF edge
        IDLE_LIM = 8'd1; STAT_CLR = 1'b1;
        cycle();
        STAT_CLR = 1'b0;
        cycles(10);
        check("stat_ten", 32'(STAT_CNT[STAT_W-1:0]), 32'd10);
        STAT_CLR = 1'b1;
        cycle();
        STAT_CLR = 1'b0;
        check("stat_clr", 32'(STAT_CNT[STAT_W-1:0]), 32'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) IDLE_LIM = IDLE_W'($urandom_range(0, 6));
            for (int c = 0; c < NCH; c++) begin
                BUSY[c]     = ($urandom_range(0, 3) == 0);
                FORCE_ON[c] = ($urandom_range(0, 15) == 0);
            end
            SE  = ($urandom_range(0, 19) == 0);
            RST = ($urandom_range(0, 99) == 0);
`ifdef M_CG_BANK_STATS_EN
            STAT_CLR = ($urandom_range(0, 29) == 0);
`endif
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
